// File: rtl/cache_mgmt_unit_pkg.sv
// Shared definitions for the cache management unit.
//   - address field widths for the direct-mapped cache (tag/index/word/byte)
//   - width/sign codes carried on u_b_h_w
//   - FSM state encoding, also visible on the debug port
//   - block_addr(): builds a word-aligned address inside a cache block
package cache_mgmt_unit_pkg;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int TAG_W         = 23;  // addr[31:9]
  localparam int INDEX_W       = 5;   // addr[8:4]
  localparam int WORD_W        = 2;   // addr[3:2]
  localparam int BYTE_W        = 2;   // addr[1:0]
  localparam int ELEMENT_WORDS = 4;   // words per cache block

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(ELEMENT_WORDS - 1);

  // Width/sign codes (load: sign-extended unless the U bit [2] is set).
  localparam logic [2:0] UBHW_B  = 3'b000;
  localparam logic [2:0] UBHW_H  = 3'b001;
  localparam logic [2:0] UBHW_W  = 3'b010;
  localparam logic [2:0] UBHW_BU = 3'b100;
  localparam logic [2:0] UBHW_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_BACK_RD = 3'd2,
    S_BACK_WR = 3'd3,
    S_FILL    = 3'd4
  } cmu_state_t;

  function automatic logic [ADDR_W-1:0] block_addr(
    input logic [TAG_W-1:0]   tag,
    input logic [INDEX_W-1:0] index,
    input logic [WORD_W-1:0]  word
  );
    return {tag, index, word, {BYTE_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_mgmt_unit_if.sv
// Bus bundle between the CPU, the cache array, main memory and the cache
// management unit.
//   slave  : the view taken by cache_mgmt_unit
//   master : the view taken by the surrounding system (CPU, cache, memory)
//
// Handshakes:
//   CPU    -> en_r/en_w with addr_rw/u_b_h_w/data_w are held stable while
//             stall is high; the request completes on the rising edge where
//             stall is low (data_r is valid after that edge for reads).
//   memory -> mem_cs_o with mem_we_o/mem_addr_o/mem_data_o are held stable
//             until the one-cycle mem_ack_i pulse; the word transfers on that
//             edge (mem_data_i is sampled in the ack cycle for reads).
//   cache  -> cache_* strobes are single-cycle; cache_hit/valid/dirty/tag/dout
//             are registered and reflect the previous cycle's cache_addr.
interface cache_mgmt_unit_if;
  import cache_mgmt_unit_pkg::*;

  // CPU side
  logic              en_r;
  logic              en_w;
  logic [ADDR_W-1:0] addr_rw;
  logic [2:0]        u_b_h_w;
  logic [DATA_W-1:0] data_w;
  logic [DATA_W-1:0] data_r;
  logic              stall;

  // Cache array side
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_din;
  logic [2:0]        cache_u_b_h_w;
  logic              cache_load;
  logic              cache_edit;
  logic              cache_store;
  logic              cache_hit;
  logic              cache_valid;
  logic              cache_dirty;
  logic [TAG_W-1:0]  cache_tag;
  logic [DATA_W-1:0] cache_dout;

  // Memory side
  logic              mem_cs_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  en_r, en_w, addr_rw, u_b_h_w, data_w,
    output data_r, stall,
    output cache_addr, cache_din, cache_u_b_h_w, cache_load, cache_edit, cache_store,
    input  cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
    output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport master (
    output en_r, en_w, addr_rw, u_b_h_w, data_w,
    input  data_r, stall,
    input  cache_addr, cache_din, cache_u_b_h_w, cache_load, cache_edit, cache_store,
    output cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
    input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );

endinterface

// File: rtl/cache_mgmt_unit.sv
// Cache management unit: sits between the CPU and a direct-mapped,
// write-back cache with 4-word blocks, and refills/evicts blocks from main
// memory one word at a time.
//
// Ports:
//   clk       : sole clock, rising edge
//   rst       : synchronous, active-high; returns to S_IDLE and abandons any
//               memory access in flight
//   bus       : cache_mgmt_unit_if.slave (CPU, cache array and memory buses)
//   dbg_state : current FSM state
//
// Flow: S_IDLE issues the CPU access to the cache, S_CHECK inspects the
// registered hit result. A miss on a dirty valid block writes the victim
// back (S_BACK_RD reads one word from the cache, S_BACK_WR sends it to
// memory), then S_FILL brings in the requested block. After the fill the FSM
// returns to S_IDLE with the CPU request still pending, so the access is
// simply reissued and hits.
module cache_mgmt_unit
  import cache_mgmt_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_mgmt_unit_if.slave   bus,
  output cmu_state_t         dbg_state
);

  cmu_state_t          state_q, state_d;
  logic [WORD_W-1:0]   cnt_q, cnt_d;

  // The CPU holds its request stable until stall drops, so only the block
  // fields needed while the cache is busy with other addresses are captured.
  logic [TAG_W-1:0]    req_tag_q;
  logic [INDEX_W-1:0]  req_index_q;
  logic                is_read_q;
  logic [TAG_W-1:0]    victim_tag_q;
  logic [DATA_W-1:0]   wb_data_q;
  logic                wb_first_q;
  logic [DATA_W-1:0]   data_r_q;

  logic                req;
  logic                latch_req;
  logic                latch_victim;
  logic                load_rdata;

  assign req       = bus.en_r | bus.en_w;
  assign dbg_state = state_q;
  assign bus.data_r = data_r_q;

  // Next-state and output decode.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    latch_req         = 1'b0;
    latch_victim      = 1'b0;
    load_rdata        = 1'b0;
    bus.stall         = 1'b0;
    bus.cache_addr    = '0;
    bus.cache_din     = '0;
    bus.cache_u_b_h_w = '0;
    bus.cache_load    = 1'b0;
    bus.cache_edit    = 1'b0;
    bus.cache_store   = 1'b0;
    bus.mem_cs_o      = 1'b0;
    bus.mem_we_o      = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_data_o    = '0;

    // Only a hit in S_CHECK lets the CPU proceed.
    bus.stall = req & ~((state_q == S_CHECK) & bus.cache_hit);

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          bus.cache_addr    = bus.addr_rw;
          bus.cache_din     = bus.data_w;
          bus.cache_u_b_h_w = bus.u_b_h_w;
          // Write wins when both enables are high.
          bus.cache_edit    = bus.en_w;
          bus.cache_load    = bus.en_r & ~bus.en_w;
          latch_req         = 1'b1;
          state_d           = S_CHECK;
        end
      end

      S_CHECK: begin
        if (bus.cache_hit) begin
          load_rdata = is_read_q;
          state_d    = S_IDLE;
        end else begin
          latch_victim = 1'b1;
          cnt_d        = '0;
          state_d      = (bus.cache_valid & bus.cache_dirty) ? S_BACK_RD : S_FILL;
        end
      end

      S_BACK_RD: begin
        bus.cache_addr = block_addr(victim_tag_q, req_index_q, cnt_q);
        state_d        = S_BACK_WR;
      end

      S_BACK_WR: begin
        bus.mem_cs_o   = 1'b1;
        bus.mem_we_o   = 1'b1;
        bus.mem_addr_o = block_addr(victim_tag_q, req_index_q, cnt_q);
        // The cache word arrives in the first cycle here; it is held in
        // wb_data_q for the remaining cycles of the memory write.
        bus.mem_data_o = wb_first_q ? bus.cache_dout : wb_data_q;
        if (bus.mem_ack_i) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = S_FILL;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_BACK_RD;
          end
        end
      end

      S_FILL: begin
        bus.mem_cs_o   = 1'b1;
        bus.mem_we_o   = 1'b0;
        bus.mem_addr_o = block_addr(req_tag_q, req_index_q, cnt_q);
        if (bus.mem_ack_i) begin
          bus.cache_store   = 1'b1;
          bus.cache_addr    = bus.mem_addr_o;
          bus.cache_din     = bus.mem_data_i;
          bus.cache_u_b_h_w = UBHW_W;
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and request/victim latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_tag_q    <= '0;
      req_index_q  <= '0;
      is_read_q    <= 1'b0;
      victim_tag_q <= '0;
      wb_data_q    <= '0;
      wb_first_q   <= 1'b0;
      data_r_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_first_q <= (state_q == S_BACK_RD);
      if (latch_req) begin
        req_tag_q   <= bus.addr_rw[ADDR_W-1 -: TAG_W];
        req_index_q <= bus.addr_rw[WORD_W+BYTE_W +: INDEX_W];
        is_read_q   <= ~bus.en_w;
      end
      if (latch_victim) begin
        victim_tag_q <= bus.cache_tag;
      end
      if (wb_first_q) begin
        wb_data_q <= bus.cache_dout;
      end
      if (load_rdata) begin
        data_r_q <= bus.cache_dout;
      end
    end
  end

endmodule
